led_blink_ctrl: RTL

Multi-channel LED pattern generator for the hardware-debug boards; the parametrised successor to the single-LED, fixed-period blinker. Each channel independently runs OFF, ON, continuous BLINK or counted BURST with a programmable period and on-time. Configuration arrives through a one-cycle write strobe, typically driven from a VIO core, and is applied glitch-free at period boundaries.

---
 rtl/led_blink_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED pattern generator.
// Each channel runs OFF, ON, continuous BLINK or counted BURST from a live
// register set. Configuration writes land in a per-channel shadow set and are
// committed either immediately (idle channel) or at the next period wrap, so a
// running pattern never shows a truncated or stretched period.
module led_blink_ctrl #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PRESCALE   = 1,
    parameter logic [1:0]  DEF_MODE   = 2'b10,
    parameter int unsigned DEF_PERIOD = 100_000_000,
    parameter int unsigned DEF_ON     = 50_000_000,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_on,
    input  logic [7:0]          cfg_count,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    localparam int unsigned        PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(PRESCALE - 1);
    localparam mode_t              RST_MODE   = mode_t'(DEF_MODE);
    localparam logic [CNT_W-1:0]   RST_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0]   RST_ON     = CNT_W'(DEF_ON);

    // Shared prescaler: one tick every PRESCALE clocks while start is high.
    logic [PS_W-1:0] presc_reg;
    logic            tick;

    assign tick = start && (presc_reg == PS_LAST);

    // Prescaler counts 0..PRESCALE-1 and freezes when start is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (start) begin
            if (presc_reg == PS_LAST) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + PS_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        // Live configuration and run state.
        mode_t            mode_reg, mode_next;
        logic [CNT_W-1:0] period_reg, period_next;
        logic [CNT_W-1:0] on_reg, on_next;
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic [7:0]       remaining_reg, remaining_next;
        // Shadow configuration waiting for a commit.
        mode_t            sh_mode_reg, sh_mode_next;
        logic [CNT_W-1:0] sh_period_reg, sh_period_next;
        logic [CNT_W-1:0] sh_on_reg, sh_on_next;
        logic [7:0]       sh_count_reg, sh_count_next;
        logic             pending_reg, pending_next;
        // First edge after reset starts the default configuration.
        logic             init_reg;
        // Registered outputs.
        logic             led_reg, led_next;
        logic             busy_reg, busy_next;
        logic             done_reg, done_next;

        logic             wr_hit;
        logic             running;
        logic             wrap;
        logic             commit;
        logic [CNT_W-1:0] period_eff;
        logic [CNT_W-1:0] cnt_inc;

        // Out-of-range channel numbers simply never match any channel.
        assign wr_hit     = cfg_we && (cfg_ch == CH_W'(gi));
        // A period below 2 would leave no room for both levels; clamp it.
        assign period_eff = (period_reg < CNT_W'(2)) ? CNT_W'(2) : period_reg;
        assign cnt_inc    = cnt_reg + CNT_W'(1);
        assign wrap       = (cnt_reg == (period_eff - CNT_W'(1)));
        // OFF, ON and an exhausted BURST are idle and accept commits at once.
        assign running    = (mode_reg == MODE_BLINK) ||
                            ((mode_reg == MODE_BURST) && (remaining_reg != 8'd0));
        assign commit     = !init_reg && pending_reg && (!running || (tick && wrap));

        // Next-state logic: start-up, commit, advance, then shadow write.
        always_comb begin
            mode_next      = mode_reg;
            period_next    = period_reg;
            on_next        = on_reg;
            cnt_next       = cnt_reg;
            remaining_next = remaining_reg;
            sh_mode_next   = sh_mode_reg;
            sh_period_next = sh_period_reg;
            sh_on_next     = sh_on_reg;
            sh_count_next  = sh_count_reg;
            pending_next   = pending_reg;
            led_next       = led_reg;
            busy_next      = busy_reg;
            done_next      = 1'b0;

            if (init_reg) begin
                // Bring the reset configuration up without consuming a tick.
                cnt_next  = '0;
                busy_next = running;
                if (running) begin
                    led_next = (on_reg != '0);
                end else begin
                    led_next = (mode_reg == MODE_ON);
                end
            end else if (commit) begin
                mode_next      = sh_mode_reg;
                period_next    = sh_period_reg;
                on_next        = sh_on_reg;
                remaining_next = sh_count_reg;
                cnt_next       = '0;
                pending_next   = 1'b0;
                case (sh_mode_reg)
                    MODE_OFF: begin
                        led_next  = 1'b0;
                        busy_next = 1'b0;
                    end
                    MODE_ON: begin
                        led_next  = 1'b1;
                        busy_next = 1'b0;
                    end
                    MODE_BLINK: begin
                        led_next  = (sh_on_reg != '0);
                        busy_next = 1'b1;
                    end
                    MODE_BURST: begin
                        if (sh_count_reg == 8'd0) begin
                            // An empty burst finishes on the commit edge.
                            led_next  = 1'b0;
                            busy_next = 1'b0;
                            done_next = 1'b1;
                        end else begin
                            led_next  = (sh_on_reg != '0);
                            busy_next = 1'b1;
                        end
                    end
                    default: begin
                        led_next  = 1'b0;
                        busy_next = 1'b0;
                    end
                endcase
            end else if (running && tick) begin
                if (wrap) begin
                    cnt_next = '0;
                    if ((mode_reg == MODE_BURST) && (remaining_reg == 8'd1)) begin
                        // Last burst period just ended.
                        remaining_next = 8'd0;
                        led_next       = 1'b0;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                    end else begin
                        if (mode_reg == MODE_BURST) begin
                            remaining_next = remaining_reg - 8'd1;
                        end
                        led_next = (on_reg != '0);
                    end
                end else begin
                    cnt_next = cnt_inc;
                    led_next = (cnt_inc < on_reg);
                end
            end

            // A write in the same cycle as a commit becomes the next pending set.
            if (wr_hit) begin
                sh_mode_next   = mode_t'(cfg_mode);
                sh_period_next = cfg_period;
                sh_on_next     = cfg_on;
                sh_count_next  = cfg_count;
                pending_next   = 1'b1;
            end
        end

        // Channel state registers with synchronous reset to the defaults.
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_reg      <= RST_MODE;
                period_reg    <= RST_PERIOD;
                on_reg        <= RST_ON;
                cnt_reg       <= '0;
                remaining_reg <= 8'd0;
                sh_mode_reg   <= RST_MODE;
                sh_period_reg <= RST_PERIOD;
                sh_on_reg     <= RST_ON;
                sh_count_reg  <= 8'd0;
                pending_reg   <= 1'b0;
                init_reg      <= 1'b1;
                led_reg       <= 1'b0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b0;
            end else begin
                mode_reg      <= mode_next;
                period_reg    <= period_next;
                on_reg        <= on_next;
                cnt_reg       <= cnt_next;
                remaining_reg <= remaining_next;
                sh_mode_reg   <= sh_mode_next;
                sh_period_reg <= sh_period_next;
                sh_on_reg     <= sh_on_next;
                sh_count_reg  <= sh_count_next;
                pending_reg   <= pending_next;
                init_reg      <= 1'b0;
                led_reg       <= led_next;
                busy_reg      <= busy_next;
                done_reg      <= done_next;
            end
        end

        assign led[gi]  = led_reg;
        assign busy[gi] = busy_reg;
        assign done[gi] = done_reg;
    end

endmodule
